// File: rtl/sparserdes_pkg.sv
// sparserdes_pkg: shared state encoding and tree-node range helper for the sparse link
package sparserdes_pkg;

    localparam int MAX_SIZE = 256;

    typedef enum logic [1:0] {IDLE, START, EMIT_LO, EMIT_HI} state_e;

    // Leaves covered by node (level, prefix): leaf i belongs when its address above bit `level` equals prefix
    function automatic logic [MAX_SIZE-1:0] node_mask(input int level, input int prefix);
        node_mask = '0;
        if (level >= 0)
            for (int i = 0; i < MAX_SIZE; i++)
                node_mask[i] = (i >> level) == prefix;
    endfunction

endpackage

// File: rtl/sparserdes_occupancy.sv
// sparserdes_occupancy: {low-half, high-half} nonempty flags of one tree node over an event vector
module sparserdes_occupancy import sparserdes_pkg::*; #(
    parameter int SIZE  = 16,
    parameter int DEPTH = $clog2(SIZE),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic [SIZE-1:0]  vec_i,
    input  logic [LW-1:0]    level_i,
    input  logic [DEPTH-1:0] base_i,
    output logic             lo_o,
    output logic             hi_o
);

    logic [MAX_SIZE-1:0] lo_m, hi_m;
    int sub, pfx;

    // Children sit one level down; the node base is aligned, so the low child prefix is even
    always_comb begin
        sub  = int'(level_i) - 1;
        pfx  = sub < 0 ? 0 : int'(base_i) >> sub;
        lo_m = node_mask(sub, pfx);
        hi_m = node_mask(sub, pfx | 1);
        lo_o = |(MAX_SIZE'(vec_i) & lo_m);
        hi_o = |(MAX_SIZE'(vec_i) & hi_m);
    end

endmodule

// File: rtl/sparserdes_encoder.sv
// sparserdes_encoder: depth-first tree-coded serializer of a sparse event vector
// Optional: SPARSERDES_ENC_STATS_EN adds stat_bits, the bit count of the last completed frame
module sparserdes_encoder import sparserdes_pkg::*; #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [SIZE-1:0] load_data,
    output logic            frame_start,
    output logic            bitstream,
    output logic            bit_valid,
    input  logic            bit_ready,
    output logic            frame_end,
`ifdef SPARSERDES_ENC_STATS_EN
    output logic [$clog2(2*SIZE)-1:0] stat_bits,
`endif
    output logic            busy
);

    localparam int DEPTH = $clog2(SIZE);
    localparam int LW    = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic [SIZE-1:0]  vec_q, vec_d;
    logic [LW-1:0]    level_q, level_d, up;
    logic [DEPTH-1:0] base_q, base_d;
    logic [DEPTH:1]   pend_q, pend_d;
    logic             lo_q, hi_q, nxt_lo, nxt_hi, found, more, last_d;

    // Occupancy is evaluated on the next node so the serial outputs can be registered
    sparserdes_occupancy #(.SIZE(SIZE), .DEPTH(DEPTH), .LW(LW)) u_occ (
        .vec_i   (vec_d),
        .level_i (level_d),
        .base_i  (base_d),
        .lo_o    (nxt_lo),
        .hi_o    (nxt_hi)
    );

    // Tree walk: descend low first, remember a nonempty high sibling as a pending bit, resume at the nearest one
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        level_d = level_q;
        base_d  = base_q;
        pend_d  = pend_q;
        found   = 1'b0;
        up      = '0;
        for (int p = DEPTH; p >= 1; p--)
            if (p > int'(level_q) && pend_q[LW'(p)]) begin
                found = 1'b1;
                up    = LW'(p);
            end
        case (state_q)
            IDLE: if (load_valid) begin
                vec_d   = load_data;
                level_d = LW'(DEPTH);
                base_d  = '0;
                pend_d  = '0;
                state_d = START;
            end
            START: state_d = EMIT_LO;
            EMIT_LO: if (bit_ready) state_d = EMIT_HI;
            EMIT_HI: if (bit_ready) begin
                state_d = EMIT_LO;
                if (int'(level_q) > 1 && lo_q) begin
                    pend_d[level_q] = hi_q;
                    level_d         = level_q - 1'b1;
                end else if (int'(level_q) > 1 && hi_q) begin
                    base_d  = base_q | DEPTH'(1 << (int'(level_q) - 1));
                    level_d = level_q - 1'b1;
                end else if (found) begin
                    pend_d[up] = 1'b0;
                    level_d    = up - 1'b1;
                    base_d     = (base_q & ~DEPTH'((1 << int'(up)) - 1)) | DEPTH'(1 << (int'(up) - 1));
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        more = 1'b0;
        for (int p = DEPTH; p >= 1; p--)
            if (p > int'(level_d) && pend_d[LW'(p)]) more = 1'b1;
        last_d = !(int'(level_d) > 1 && (nxt_lo || nxt_hi)) && !more;
    end

    // State and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            level_q     <= '0;
            base_q      <= '0;
            pend_q      <= '0;
            lo_q        <= 1'b0;
            hi_q        <= 1'b0;
            load_ready  <= 1'b1;
            frame_start <= 1'b0;
            bitstream   <= 1'b0;
            bit_valid   <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            level_q     <= level_d;
            base_q      <= base_d;
            pend_q      <= pend_d;
            lo_q        <= nxt_lo;
            hi_q        <= nxt_hi;
            load_ready  <= state_d == IDLE;
            frame_start <= state_d == START;
            bitstream   <= state_d == EMIT_LO ? nxt_lo : state_d == EMIT_HI ? nxt_hi : 1'b0;
            bit_valid   <= state_d == EMIT_LO || state_d == EMIT_HI;
            frame_end   <= state_d == EMIT_HI && last_d;
            busy        <= state_d != IDLE;
        end
    end

`ifdef SPARSERDES_ENC_STATS_EN
    logic [$clog2(2*SIZE)-1:0] cnt_q;

    // Count accepted bits of the current frame and publish the total when its last bit is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            stat_bits <= '0;
        end else if (load_ready && load_valid) begin
            cnt_q <= '0;
        end else if (bit_valid && bit_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (frame_end) stat_bits <= cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sparserdes_encoder.sv
// tb_sparserdes_encoder: table, corner-case and randomized checks of the sparse tree encoder (SIZE=8)
module tb_sparserdes_encoder;

    localparam int SIZE = 8;

    logic       clk = 1'b0;
    logic       reset, load_valid, load_ready, frame_start, bitstream, bit_valid, bit_ready, frame_end, busy;
    logic [7:0] load_data;
`ifdef SPARSERDES_ENC_STATS_EN
    logic [3:0] stat_bits;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  vec;
        int          len;
        logic [31:0] bits;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    sparserdes_encoder #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .frame_start (frame_start),
        .bitstream   (bitstream),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .frame_end   (frame_end),
`ifdef SPARSERDES_ENC_STATS_EN
        .stat_bits   (stat_bits),
`endif
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: explicit DFS stack over nodes, occupancy counted leaf by leaf
    function automatic void model(input logic [7:0] v, output logic [31:0] bits, output int len);
        int lv[$];
        int pf[$];
        bits = '0;
        len  = 0;
        lv.push_back(3);
        pf.push_back(0);
        while (lv.size() > 0) begin
            int   l    = lv.pop_back();
            int   p    = pf.pop_back();
            int   half = 1 << (l - 1);
            logic lo   = 1'b0;
            logic hi   = 1'b0;
            for (int i = 0; i < half; i++) begin
                lo |= v[p * 2 * half + i];
                hi |= v[p * 2 * half + half + i];
            end
            bits = {bits[29:0], lo, hi};
            len += 2;
            if (l > 1) begin
                if (hi) begin lv.push_back(l - 1); pf.push_back(2 * p + 1); end
                if (lo) begin lv.push_back(l - 1); pf.push_back(2 * p); end
            end
        end
    endfunction

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_frame(input logic [7:0] v, input int mode, output logic [31:0] got, output int len, output int cycles);
        int   k = 0;
        logic stalled = 1'b0;
        logic done = 1'b0;
        logic pb = 1'b0;
        logic pfe = 1'b0;
        got    = '0;
        len    = 0;
        cycles = 0;
        @(negedge clk);
        check("load_ready_idle", load_ready, 1);
        load_valid = 1'b1;
        load_data  = v;
        @(negedge clk);
        load_valid = 1'b0;
        cycles     = 1;
        check("frame_start", frame_start, 1);
        check("start_no_valid", bit_valid, 0);
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            bit_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : ($urandom_range(0, 2) != 0);
            k++;
            if (cycles == 2) check("start_pulse", frame_start, 0);
            if (stalled) begin
                check("stall_valid", bit_valid, 1);
                check("stall_bit", bitstream, pb);
                check("stall_end", frame_end, pfe);
            end
            stalled = bit_valid && !bit_ready;
            pb      = bitstream;
            pfe     = frame_end;
            if (bit_valid && bit_ready) begin
                got  = {got[30:0], bitstream};
                len++;
                done = frame_end;
            end
        end
        if (!done) check("frame_timeout", 0, 1);
        @(negedge clk);
        bit_ready = 1'b0;
        check("load_ready_after", load_ready, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        logic [31:0] got, exp_bits;
        int          len, cycles, exp_len;
        logic [7:0]  v;
        tbl[0] = '{8'h01, 6, 32'b101010};
        tbl[1] = '{8'h81, 10, 32'b1110100101};
        tbl[2] = '{8'h00, 2, 32'b00};
        tbl[3] = '{8'hFF, 14, 32'h3FFF};
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        bit_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_load_ready", load_ready, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_bitstream", bitstream, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_busy", busy, 0);
`ifdef SPARSERDES_ENC_STATS_EN
        check("rst_stat", stat_bits, 0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].vec, 0, got, len, cycles);
            check("tbl_bits", got, tbl[i].bits);
            check("tbl_len", len, tbl[i].len);
            check("tbl_latency", cycles, tbl[i].len + 1);
`ifdef SPARSERDES_ENC_STATS_EN
            check("tbl_stat", stat_bits, tbl[i].len);
`endif
        end
        run_frame(8'h81, 1, got, len, cycles);
        check("stall_bits", got, tbl[1].bits);
        check("stall_len", len, 10);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h81;
        bit_ready  = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_valid_before", bit_valid, 1);
        reset = 1'b1;
        #1;
        check("abort_valid", bit_valid, 0);
        check("abort_load_ready", load_ready, 1);
        check("abort_busy", busy, 0);
`ifdef SPARSERDES_ENC_STATS_EN
        check("abort_stat", stat_bits, 0);
`endif
        @(negedge clk);
        reset     = 1'b0;
        bit_ready = 1'b0;
        run_frame(8'h01, 0, got, len, cycles);
        check("post_abort_bits", got, tbl[0].bits);
        check("post_abort_len", len, 6);
        for (int i = 0; i < 25; i++) begin
            v = 8'($urandom);
            if (i % 3 == 0) v = v & 8'($urandom);
            model(v, exp_bits, exp_len);
            run_frame(v, 2, got, len, cycles);
            check("rand_bits", got, exp_bits);
            check("rand_len", len, exp_len);
`ifdef SPARSERDES_ENC_STATS_EN
            check("rand_stat", stat_bits, exp_len);
`endif
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
